horner_poly_engine: RTL and testbench

- Parametrised successor to the NLA single-function sequencer: one block that holds the controller, coefficient storage and a saturating fixed-point Horner datapath.
- Evaluates y = sum c[i]*x^i for one of N_FUNC programmable functions, at one MAC per cycle.
- Uses valid/ready handshakes on input and output and supports sign-symmetry modes.
- Sits between the activation input stream and the result buffer of the NonLinearApprox engine.

---
 rtl/nla_pkg.sv | 31 +++
 rtl/horner_poly_engine_if.sv | 28 ++
 rtl/horner_mac_sat.sv | 62 ++++++
 rtl/horner_poly_engine.sv | 210 +++++++++++++++++++++
 tb/tb_horner_poly_engine.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nla_pkg.sv
// Shared types and Q-format constants for the NonLinearApprox engine.
// Holds mode encodings, the sequencer state enum and default Q4.12 limits.
package nla_pkg;

   typedef enum logic [1:0] {
      MODE_PLAIN    = 2'b00,
      MODE_ODD      = 2'b01,
      MODE_EVEN     = 2'b10,
      MODE_PASS_POS = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_MAC,
      S_POST,
      S_OUT
   } state_e;

   localparam int DATA_W_DEF = 16;
   localparam int FRAC_W_DEF = 12;
   localparam int ONE        = 1 << FRAC_W_DEF;
   localparam int SAT_MAX    = (1 << (DATA_W_DEF - 1)) - 1;
   localparam int SAT_MIN    = -(1 << (DATA_W_DEF - 1));

   // Index width that stays legal for single-entry tables.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/horner_poly_engine_if.sv
// Operand/result handshake bundle of the Horner engine.
// slave: engine side (in_* in, out_* out); master: producer/consumer side.
interface horner_poly_engine_if
   import nla_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FUNC_W = 2
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_x;
   logic [FUNC_W-1:0] in_func;
   mode_e             in_mode;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_y;
   logic              out_sat;

   modport slave (
      input  in_valid, in_x, in_func, in_mode, out_ready,
      output in_ready, out_valid, out_y, out_sat
   );

   modport master (
      output in_valid, in_x, in_func, in_mode, out_ready,
      input  in_ready, out_valid, out_y, out_sat
   );
endinterface

// File: rtl/horner_mac_sat.sv
// One Horner step: acc_next = sat(sat(round(acc*x)) + coef).
// Ports: acc, x, coef in; acc_next, sat (any clamp) out. Purely combinational.
module horner_mac_sat #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 12
) (
   input  logic signed [DATA_W-1:0] acc,
   input  logic signed [DATA_W-1:0] x,
   input  logic signed [DATA_W-1:0] coef,
   output logic signed [DATA_W-1:0] acc_next,
   output logic                     sat
);
   localparam int MW = 2 * DATA_W;
   localparam int PW = MW + 1;

   localparam logic signed [DATA_W-1:0] D_MAX =
      {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] D_MIN =
      {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [PW-1:0] W_MAX =
      {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [PW-1:0] W_MIN =
      {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   localparam logic signed [PW-1:0] RND =
      {{(PW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

   logic signed [MW-1:0]     prod;
   logic signed [PW-1:0]     prod_r;
   logic signed [PW-1:0]     shf;
   logic signed [DATA_W-1:0] r_sat;
   logic        [DATA_W:0]   sum;
   logic                     r_hi;
   logic                     r_lo;
   logic                     s_clip;

   // One guard bit above the product keeps the rounding add exact.
   assign prod   = MW'(acc) * MW'(x);
   assign prod_r = PW'(prod) + RND;
   assign shf    = prod_r >>> FRAC_W;

   assign r_hi = shf > W_MAX;
   assign r_lo = shf < W_MIN;

   always_comb begin
      r_sat = shf[DATA_W-1:0];
      if (r_hi) r_sat = D_MAX;
      if (r_lo) r_sat = D_MIN;
   end

   assign sum = {r_sat[DATA_W-1], r_sat}
              + {coef[DATA_W-1], coef};

   // Sign bit and guard bit disagree only on overflow.
   assign s_clip = sum[DATA_W] ^ sum[DATA_W-1];

   always_comb begin
      acc_next = sum[DATA_W-1:0];
      if (s_clip) acc_next = sum[DATA_W] ? D_MIN : D_MAX;
   end

   assign sat = r_hi | r_lo | s_clip;
endmodule

// File: rtl/horner_poly_engine.sv
// Programmable saturating fixed-point polynomial evaluator (Horner, 1 MAC/cycle).
// Ports: clk, rst_n; cfg_* coefficient/degree writes, cfg_err drop pulse;
// io (slave) operand/result handshake; busy while an evaluation is in flight.
module horner_poly_engine
   import nla_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int FRAC_W  = 12,
   parameter int MAX_DEG = 7,
   parameter int N_FUNC  = 4,
   localparam int FW     = idx_w(N_FUNC),
   localparam int IW     = idx_w(MAX_DEG + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [FW-1:0]     cfg_func,
   input  logic [IW-1:0]     cfg_idx,
   input  logic [DATA_W-1:0] cfg_coeff,
   input  logic              cfg_deg_we,
   input  logic [IW-1:0]     cfg_deg,
   output logic              cfg_err,
   horner_poly_engine_if.slave io,
   output logic              busy
);
   localparam logic signed [DATA_W-1:0] D_MAX =
      {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] D_MIN =
      {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [IW-1:0] DEG_TOP = IW'(MAX_DEG);

   state_e state_q;
   state_e state_d;

   logic signed [DATA_W-1:0] coef_q [N_FUNC][MAX_DEG+1];
   logic [IW-1:0]            deg_q  [N_FUNC];

   logic signed [DATA_W-1:0] x_q;
   logic signed [DATA_W-1:0] xe_q;
   logic [FW-1:0]            func_q;
   mode_e                    mode_q;
   logic                     abs_sat_q;
   logic signed [DATA_W-1:0] acc_q;
   logic [IW-1:0]            cnt_q;
   logic                     sat_q;
   logic signed [DATA_W-1:0] y_q;
   logic                     ysat_q;
   logic                     cfg_err_q;

   logic                     accept;
   logic                     use_abs;
   logic                     x_min_in;
   logic signed [DATA_W-1:0] xe_in;
   logic [IW-1:0]            deg_sel;
   logic [IW-1:0]            cnt_m1;
   logic signed [DATA_W-1:0] coef_top;
   logic signed [DATA_W-1:0] coef_mac;
   logic signed [DATA_W-1:0] mac_acc;
   logic                     mac_sat;
   logic                     x_pos;
   logic                     short_path;
   logic signed [DATA_W-1:0] y_post;
   logic                     s_post;
   logic                     cfg_hit;
   logic                     cfg_drop;
   logic                     func_ok;
   logic [IW-1:0]            deg_wr;

   assign busy        = state_q != S_IDLE;
   assign io.in_ready = state_q == S_IDLE;
   assign io.out_valid = state_q == S_OUT;
   assign io.out_y    = y_q;
   assign io.out_sat  = ysat_q;
   assign cfg_err     = cfg_err_q;

   assign accept = io.in_valid && io.in_ready;

   // Symmetric modes evaluate at |x|; -MIN is not representable.
   assign use_abs  = (io.in_mode == MODE_ODD
                   || io.in_mode == MODE_EVEN)
                   && io.in_x[DATA_W-1];
   assign x_min_in = io.in_x == D_MIN;

   always_comb begin
      xe_in = io.in_x;
      if (use_abs) xe_in = x_min_in ? D_MAX : -io.in_x;
   end

   assign deg_sel  = deg_q[func_q];
   assign cnt_m1   = cnt_q - IW'(1);
   assign coef_top = coef_q[func_q][deg_sel];
   assign coef_mac = coef_q[func_q][cnt_m1];
   assign x_pos    = !x_q[DATA_W-1];

   assign short_path = (deg_sel == '0)
                    || (mode_q == MODE_PASS_POS && x_pos);

   horner_mac_sat #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
   ) u_mac (
      .acc      (acc_q),
      .x        (xe_q),
      .coef     (coef_mac),
      .acc_next (mac_acc),
      .sat      (mac_sat)
   );

   always_comb begin
      y_post = acc_q;
      s_post = sat_q;
      if (mode_q == MODE_PASS_POS && x_pos) begin
         y_post = x_q;
      end else if (mode_q == MODE_ODD && !x_pos) begin
         if (acc_q == D_MIN) begin
            y_post = D_MAX;
            s_post = 1'b1;
         end else begin
            y_post = -acc_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept) state_d = S_LOAD;
         S_LOAD: state_d = short_path ? S_POST : S_MAC;
         S_MAC:  if (cnt_q == IW'(1)) state_d = S_POST;
         S_POST: state_d = S_OUT;
         S_OUT:  if (io.out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q       <= '0;
         xe_q      <= '0;
         func_q    <= '0;
         mode_q    <= MODE_PLAIN;
         abs_sat_q <= 1'b0;
         acc_q     <= '0;
         cnt_q     <= '0;
         sat_q     <= 1'b0;
         y_q       <= '0;
         ysat_q    <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  x_q       <= io.in_x;
                  xe_q      <= xe_in;
                  func_q    <= io.in_func;
                  mode_q    <= io.in_mode;
                  abs_sat_q <= use_abs && x_min_in;
               end
            end
            S_LOAD: begin
               acc_q <= coef_top;
               cnt_q <= deg_sel;
               sat_q <= abs_sat_q;
            end
            S_MAC: begin
               acc_q <= mac_acc;
               cnt_q <= cnt_m1;
               sat_q <= sat_q | mac_sat;
            end
            S_POST: begin
               y_q    <= y_post;
               ysat_q <= s_post;
            end
            default: ;
         endcase
      end
   end

   // The slot being evaluated is frozen until the engine is idle again.
   assign cfg_hit  = busy && cfg_func == func_q;
   assign cfg_drop = (cfg_we || cfg_deg_we) && cfg_hit;
   assign func_ok  = 32'(cfg_func) < N_FUNC;
   assign deg_wr   = (cfg_deg > DEG_TOP) ? DEG_TOP : cfg_deg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_err_q <= 1'b0;
         for (int f = 0; f < N_FUNC; f++) begin
            deg_q[f] <= '0;
            for (int i = 0; i <= MAX_DEG; i++) begin
               coef_q[f][i] <= '0;
            end
         end
      end else begin
         cfg_err_q <= cfg_drop;
         if (!cfg_hit && func_ok) begin
            if (cfg_we && cfg_idx <= DEG_TOP) begin
               coef_q[cfg_func][cfg_idx] <= cfg_coeff;
            end
            if (cfg_deg_we) begin
               deg_q[cfg_func] <= deg_wr;
            end
         end
      end
   end
endmodule

// File: tb/tb_horner_poly_engine.sv
// Self-checking bench for horner_poly_engine.
// Directed plan cases plus random operands against a plain-arithmetic model.
module tb_horner_poly_engine;
   import nla_pkg::*;

   localparam int  DW   = 16;
   localparam int  FR   = 12;
   localparam longint MAXV = 32767;
   localparam longint MINV = -32768;
   localparam longint HALF = 2048;

   logic        clk;
   logic        rst_n;
   logic        cfg_we;
   logic [1:0]  cfg_func;
   logic [2:0]  cfg_idx;
   logic [15:0] cfg_coeff;
   logic        cfg_deg_we;
   logic [2:0]  cfg_deg;
   logic        cfg_err;
   logic        busy;

   horner_poly_engine_if #(.DATA_W(DW), .FUNC_W(2)) io ();

   horner_poly_engine #(
      .DATA_W  (DW),
      .FRAC_W  (FR),
      .MAX_DEG (7),
      .N_FUNC  (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_we     (cfg_we),
      .cfg_func   (cfg_func),
      .cfg_idx    (cfg_idx),
      .cfg_coeff  (cfg_coeff),
      .cfg_deg_we (cfg_deg_we),
      .cfg_deg    (cfg_deg),
      .cfg_err    (cfg_err),
      .io         (io),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int     n_chk;
   int     n_fail;
   longint cm [4][8];
   int     dm [4];

   function automatic longint sat(input longint v, inout logic s);
      if (v > MAXV) begin s = 1'b1; return MAXV; end
      if (v < MINV) begin s = 1'b1; return MINV; end
      return v;
   endfunction

   // y = sum c[i]*x^i in Horner order with Q-format rounding.
   function automatic void ref_eval(
      input  logic [15:0] x,
      input  int          f,
      input  mode_e       m,
      output logic [15:0] y,
      output logic        s,
      output int          lat
   );
      longint xv, xe, acc, r;
      int d;
      s  = 1'b0;
      xv = longint'($signed(x));
      xe = xv;
      d  = dm[f];
      if ((m == MODE_ODD || m == MODE_EVEN) && xv < 0) begin
         xe = -xv;
         if (xe > MAXV) begin xe = MAXV; s = 1'b1; end
      end
      if (m == MODE_PASS_POS && xv >= 0) begin
         y = x; lat = 2;
         return;
      end
      acc = cm[f][d];
      for (int i = d; i > 0; i--) begin
         r   = (acc * xe + HALF) >>> FR;
         r   = sat(r, s);
         acc = sat(r + cm[f][i-1], s);
      end
      if (m == MODE_ODD && xv < 0) acc = sat(-acc, s);
      y   = acc[15:0];
      lat = d + 2;
   endfunction

   task automatic wr_coef(input int f, input int i, input int v);
      logic [15:0] t;
      t = v[15:0];
      cfg_func  = f[1:0];
      cfg_idx   = i[2:0];
      cfg_coeff = t;
      cfg_we    = 1'b1;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      cm[f][i] = longint'($signed(t));
   endtask

   task automatic wr_deg(input int f, input int d);
      cfg_func   = f[1:0];
      cfg_deg    = d[2:0];
      cfg_deg_we = 1'b1;
      @(posedge clk); #1;
      cfg_deg_we = 1'b0;
      dm[f] = d;
   endtask

   task automatic do_op(
      input  logic [15:0] x,
      input  int          f,
      input  mode_e       m,
      output logic [15:0] y,
      output logic        s,
      output int          lat
   );
      int n;
      io.in_x     = x;
      io.in_func  = f[1:0];
      io.in_mode  = m;
      io.in_valid = 1'b1;
      n = 0;
      while (!io.in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      io.in_valid = 1'b0;
      lat = 0;
      while (!io.out_valid && lat < 60) begin
         @(posedge clk); #1; lat++;
      end
      y = io.out_y;
      s = io.out_sat;
      io.out_ready = 1'b1;
      @(posedge clk); #1;
      io.out_ready = 1'b0;
   endtask

   task automatic test_reset;
      logic [5:0] got;
      logic [5:0] exp;
      got = {io.in_ready, io.out_valid, io.out_sat,
             cfg_err, busy, |io.out_y};
      exp = 6'b100000;
      for (int i = 0; i < 6; i++) begin
         n_chk++;
         if (got[i] !== exp[i]) begin
            $display("FAIL reset_bit%0d got %b exp %b",
                     i, got[i], exp[i]);
            n_fail++;
         end
      end
   endtask

   task automatic test_plain;
      logic [15:0] y, ey;
      logic        s, es;
      int          lat, el;
      wr_deg(0, 2);
      wr_coef(0, 0, 16'h1000);
      wr_coef(0, 1, 16'h1000);
      wr_coef(0, 2, 16'h0800);
      ref_eval(16'h1000, 0, MODE_PLAIN, ey, es, el);
      do_op(16'h1000, 0, MODE_PLAIN, y, s, lat);
      n_chk++;
      if (y !== 16'h2800) begin
         $display("FAIL plain_y got %h exp 2800", y);
         n_fail++;
      end
      n_chk++;
      if (s !== 1'b0) begin
         $display("FAIL plain_sat got %b exp 0", s);
         n_fail++;
      end
      n_chk++;
      if (lat !== 4 || el !== 4) begin
         $display("FAIL plain_lat got %0d exp 4", lat);
         n_fail++;
      end
      n_chk++;
      if (y !== ey) begin
         $display("FAIL plain_model got %h exp %h", y, ey);
         n_fail++;
      end
   endtask

   task automatic test_symmetry;
      logic [15:0] y;
      logic        s;
      int          lat;
      wr_deg(1, 1);
      wr_coef(1, 0, 0);
      wr_coef(1, 1, 16'h1000);
      do_op(16'hF000, 1, MODE_ODD, y, s, lat);
      n_chk++;
      if (y !== 16'hF000 || s !== 1'b0) begin
         $display("FAIL odd_y got %h/%b exp f000/0", y, s);
         n_fail++;
      end
      do_op(16'hF000, 1, MODE_EVEN, y, s, lat);
      n_chk++;
      if (y !== 16'h1000 || s !== 1'b0) begin
         $display("FAIL even_y got %h/%b exp 1000/0", y, s);
         n_fail++;
      end
      n_chk++;
      if (lat !== 3) begin
         $display("FAIL even_lat got %0d exp 3", lat);
         n_fail++;
      end
   endtask

   task automatic test_pass_pos;
      logic [15:0] y, ey;
      logic        s, es;
      int          lat, el;
      do_op(16'h0300, 0, MODE_PASS_POS, y, s, lat);
      n_chk++;
      if (y !== 16'h0300 || lat !== 2) begin
         $display("FAIL pass_pos got %h lat %0d exp 0300 lat 2",
                  y, lat);
         n_fail++;
      end
      ref_eval(16'hFD00, 0, MODE_PASS_POS, ey, es, el);
      do_op(16'hFD00, 0, MODE_PASS_POS, y, s, lat);
      n_chk++;
      if (y !== ey || s !== es || lat !== 4) begin
         $display("FAIL pass_neg got %h/%b lat %0d exp %h/%b lat 4",
                  y, s, lat, ey, es);
         n_fail++;
      end
   endtask

   task automatic test_saturation;
      logic [15:0] y;
      logic        s;
      int          lat;
      wr_deg(2, 1);
      wr_coef(2, 0, 16'h7FFF);
      wr_coef(2, 1, 16'h7FFF);
      do_op(16'h7FFF, 2, MODE_PLAIN, y, s, lat);
      n_chk++;
      if (y !== 16'h7FFF || s !== 1'b1) begin
         $display("FAIL sat_plain got %h/%b exp 7fff/1", y, s);
         n_fail++;
      end
      do_op(16'h8000, 2, MODE_ODD, y, s, lat);
      n_chk++;
      if (s !== 1'b1 || y !== 16'h8001) begin
         $display("FAIL sat_odd got %h/%b exp 8001/1", y, s);
         n_fail++;
      end
   endtask

   task automatic test_random;
      logic [15:0] y, ey, x;
      logic        s, es;
      int          lat, el, v;
      mode_e       m;
      for (int k = 0; k < 24; k++) begin
         if (k % 6 == 0) begin
            wr_deg(3, $urandom_range(0, 7));
            for (int i = 0; i < 8; i++) begin
               if ($urandom_range(0, 3) == 0)
                  v = $urandom_range(0, 16'hFFFF);
               else
                  v = $urandom_range(0, 16'h2000) - 16'h1000;
               wr_coef(3, i, v);
            end
         end
         x = 16'($urandom_range(0, 16'hFFFF));
         if (k % 8 == 0) x = 16'h8000;
         m = mode_e'($urandom_range(0, 3));
         ref_eval(x, 3, m, ey, es, el);
         do_op(x, 3, m, y, s, lat);
         n_chk++;
         if (y !== ey || s !== es || lat !== el) begin
            $display("FAIL rand%0d x %h m %0d got %h/%b/%0d exp %h/%b/%0d",
                     k, x, m, y, s, lat, ey, es, el);
            n_fail++;
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] y0;
      logic [15:0] y, ey;
      logic        s, es;
      int          n, el;
      ref_eval(16'h1000, 0, MODE_PLAIN, ey, es, el);
      io.in_x     = 16'h1000;
      io.in_func  = 2'd0;
      io.in_mode  = MODE_PLAIN;
      io.in_valid = 1'b1;
      @(posedge clk); #1;
      io.in_x    = 16'h0300;
      io.in_mode = MODE_PASS_POS;
      n = 0;
      while (!io.out_valid && n < 60) begin
         @(posedge clk); #1; n++;
      end
      y0 = io.out_y;
      n_chk++;
      if (y0 !== ey || n !== 4) begin
         $display("FAIL bp_first got %h lat %0d exp %h lat 4",
                  y0, n, ey);
         n_fail++;
      end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         n_chk++;
         if (io.out_y !== y0 || io.in_ready !== 1'b0
             || io.out_valid !== 1'b1) begin
            $display("FAIL bp_hold%0d y %h rdy %b vld %b exp %h 0 1",
                     c, io.out_y, io.in_ready, io.out_valid, y0);
            n_fail++;
         end
      end
      io.out_ready = 1'b1;
      @(posedge clk); #1;
      io.out_ready = 1'b0;
      n_chk++;
      if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0) begin
         $display("FAIL bp_release rdy %b vld %b exp 1 0",
                  io.in_ready, io.out_valid);
         n_fail++;
      end
      @(posedge clk); #1;
      io.in_valid = 1'b0;
      n_chk++;
      if (busy !== 1'b1) begin
         $display("FAIL bp_accept2 busy %b exp 1", busy);
         n_fail++;
      end
      n = 0;
      while (!io.out_valid && n < 60) begin
         @(posedge clk); #1; n++;
      end
      y = io.out_y;
      s = io.out_sat;
      n_chk++;
      if (y !== 16'h0300 || s !== 1'b0 || n !== 2) begin
         $display("FAIL bp_second got %h/%b lat %0d exp 0300/0 lat 2",
                  y, s, n);
         n_fail++;
      end
      io.out_ready = 1'b1;
      @(posedge clk); #1;
      io.out_ready = 1'b0;
   endtask

   task automatic test_cfg_err;
      logic [15:0] y, ey;
      logic        s, es;
      int          n, el, pulses;
      ref_eval(16'h1000, 0, MODE_PLAIN, ey, es, el);
      io.in_x     = 16'h1000;
      io.in_func  = 2'd0;
      io.in_mode  = MODE_PLAIN;
      io.in_valid = 1'b1;
      @(posedge clk); #1;
      io.in_valid = 1'b0;
      @(posedge clk); #1;
      cfg_func   = 2'd0;
      cfg_idx    = 3'd0;
      cfg_coeff  = 16'h7000;
      cfg_deg    = 3'd0;
      cfg_we     = 1'b1;
      cfg_deg_we = 1'b1;
      @(posedge clk); #1;
      cfg_deg_we = 1'b0;
      pulses = int'(cfg_err);
      cfg_func  = 2'd1;
      cfg_coeff = 16'h0100;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      cm[1][0] = 256;
      n_chk++;
      if (pulses !== 1 || cfg_err !== 1'b0) begin
         $display("FAIL cfg_err_pulse first %0d second %b exp 1 0",
                  pulses, cfg_err);
         n_fail++;
      end
      n = 0;
      while (!io.out_valid && n < 60) begin
         @(posedge clk); #1; n++;
      end
      y = io.out_y;
      s = io.out_sat;
      io.out_ready = 1'b1;
      @(posedge clk); #1;
      io.out_ready = 1'b0;
      n_chk++;
      if (y !== ey || s !== es) begin
         $display("FAIL cfg_err_result got %h/%b exp %h/%b",
                  y, s, ey, es);
         n_fail++;
      end
      ref_eval(16'h1000, 1, MODE_PLAIN, ey, es, el);
      do_op(16'h1000, 1, MODE_PLAIN, y, s, n);
      n_chk++;
      if (y !== ey || y !== 16'h1100) begin
         $display("FAIL cfg_other_slot got %h exp %h", y, ey);
         n_fail++;
      end
   endtask

   task automatic test_reset_mid;
      logic [15:0] y;
      logic        s;
      int          lat;
      io.in_x     = 16'h1000;
      io.in_func  = 2'd0;
      io.in_mode  = MODE_PLAIN;
      io.in_valid = 1'b1;
      @(posedge clk); #1;
      io.in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (io.out_valid !== 1'b0 || busy !== 1'b0
          || io.in_ready !== 1'b1) begin
         $display("FAIL rst_mid vld %b busy %b rdy %b exp 0 0 1",
                  io.out_valid, busy, io.in_ready);
         n_fail++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int f = 0; f < 4; f++) begin
         dm[f] = 0;
         for (int i = 0; i < 8; i++) cm[f][i] = 0;
      end
      @(posedge clk); #1;
      do_op(16'h1000, 0, MODE_PLAIN, y, s, lat);
      n_chk++;
      if (y !== 16'h0000 || s !== 1'b0 || lat !== 2) begin
         $display("FAIL rst_cleared got %h/%b lat %0d exp 0000/0 lat 2",
                  y, s, lat);
         n_fail++;
      end
   endtask

   initial begin
      n_chk        = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      cfg_we       = 1'b0;
      cfg_deg_we   = 1'b0;
      cfg_func     = '0;
      cfg_idx      = '0;
      cfg_coeff    = '0;
      cfg_deg      = '0;
      io.in_valid  = 1'b0;
      io.in_x      = '0;
      io.in_func   = '0;
      io.in_mode   = MODE_PLAIN;
      io.out_ready = 1'b0;
      for (int f = 0; f < 4; f++) begin
         dm[f] = 0;
         for (int i = 0; i < 8; i++) cm[f][i] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_plain();
      test_symmetry();
      test_pass_pos();
      test_saturation();
      test_random();
      test_back_to_back();
      test_cfg_err();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
